// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-sequencer FSM states and the opcodes
// the control unit also decodes.
// Latency: n/a. Backpressure: n/a.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mas_state_t;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

endpackage

// File: rtl/mem_access_sequencer_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Latency: count visible one cycle after inc_i. Backpressure: none.
// Ports: clk_i/rst_i (sync, active-high), inc_i increment, cnt_o count.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// MEM-stage load/store sequencer onto a req/ack data-memory port, with timeout.
// Latency: req one cycle after access seen; stall = ack latency + 1 cycles.
// Backpressure: stall_o freezes the whole pipeline while an access is pending.
// Ports: MemRead_i/MemWrite_i/addr_i/wdata_i from EX/MEM; mem_* to data memory;
//        stall_o to PC/pipeline enables; rdata_o to MEM/WB; err_o timeout pulse;
//        acc_cnt_o/stall_cnt_o saturating performance counters.
module mem_access_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  acc_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  mas_state_t        state, stateNxt;
  logic [WCNT_W-1:0] waitCnt;
  logic              acc;
  logic              ackSeen;
  logic              timeoutHit;

  assign acc = MemRead_i | MemWrite_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    stall_o    = 1'b0;
    ackSeen    = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        stall_o = acc;
        if (acc) stateNxt = WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        // An ack landing in the last allowed cycle wins over the timeout.
        if (mem_ack_i) begin
          ackSeen = 1'b1;
        end else if (waitCnt == WCNT_LAST) begin
          timeoutHit = 1'b1;
        end
        if (ackSeen || timeoutHit) stateNxt = DONE;
      end
      // The same instruction is still presented in DONE, so acc is ignored.
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Request is high exactly while in WAIT; state is a register, so this is
  // glitch-free and drops on the same edge as a reset.
  assign mem_req_o = (state == WAIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      waitCnt     <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= addr_i;
            mem_wdata_o <= wdata_i;
            waitCnt     <= '0;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt + WCNT_W'(1);
          if (ackSeen && !mem_we_o) rdata_o <= mem_rdata_i;
          if (timeoutHit) begin
            rdata_o <= '0;
            err_o   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) uAccCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ackSeen | timeoutHit),
    .cnt_o (acc_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) uStallCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_o),
    .cnt_o (stall_cnt_o)
  );

endmodule
